// File: rtl/cmd_arbiter_pkg.sv
// Shared controller definitions: command encodings, wait-counter index mapping
// and the refresh-handling FSM state type used by the command arbiter.
package cmd_arbiter_pkg;

  localparam int CMD_NOP  = 0;
  localparam int CMD_PRE  = 1;
  localparam int CMD_ACT  = 2;
  localparam int CMD_RD   = 3;
  localparam int CMD_WR   = 4;
  localparam int CMD_RDA  = 5;
  localparam int CMD_WRA  = 6;
  localparam int CMD_PREA = 7;

  localparam logic [1:0] CIDX_PRE = 2'd0;
  localparam logic [1:0] CIDX_ACT = 2'd1;
  localparam logic [1:0] CIDX_RD  = 2'd2;
  localparam logic [1:0] CIDX_WR  = 2'd3;

  typedef enum logic [1:0] {
    NORMAL,
    DRAIN,
    WAIT
  } arb_state_t;

  typedef struct packed {
    logic       ok;
    logic       col;
    logic       act;
    logic [1:0] idx;
  } cmd_class_t;

  // NOP, PREA and unknown encodings come back with ok=0, so they can never be granted
  function automatic cmd_class_t classify(input logic [7:0] cmd, pre, act, rd, wr, rda, wra);
    cmd_class_t c;
    c = '0;
    if (cmd == pre) begin
      c.ok  = 1'b1;
      c.idx = CIDX_PRE;
    end else if (cmd == act) begin
      c.ok  = 1'b1;
      c.act = 1'b1;
      c.idx = CIDX_ACT;
    end else if (cmd == rd || cmd == rda) begin
      c.ok  = 1'b1;
      c.col = 1'b1;
      c.idx = CIDX_RD;
    end else if (cmd == wr || cmd == wra) begin
      c.ok  = 1'b1;
      c.col = 1'b1;
      c.idx = CIDX_WR;
    end
    return c;
  endfunction

endpackage

// File: rtl/cmd_arbiter_if.sv
// Per-bank requester handshake bundle between the bank machines and the arbiter.
interface cmd_arbiter_if #(
  parameter int NUM_REQ        = 16,
  parameter int CMD_TYPE_WIDTH = 3
) ();

  logic [NUM_REQ-1:0]                     req_valid_i;
  logic [NUM_REQ-1:0][CMD_TYPE_WIDTH-1:0] req_cmd_i;
  logic [NUM_REQ-1:0]                     req_ready_o;

  modport master (output req_valid_i, req_cmd_i, input req_ready_o);
  modport slave  (input req_valid_i, req_cmd_i, output req_ready_o);

endinterface

// File: rtl/cmd_arbiter_rr_pick.sv
// Rotate-priority search: returns the first set request at or after ptr,
// wrapping around to the lowest set request below ptr.
module rr_pick #(
  parameter int N  = 16,
  parameter int PW = 5
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic          hi_found;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  // Descending scan so the lowest qualifying index is the one that sticks
  always_comb begin
    found    = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        found  = 1'b1;
        lo_idx = PW'(j);
        if (j >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(j);
        end
      end
    end
    idx = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Per-bank DRAM command arbiter: one zero-latency grant per cycle, column
// commands first, round-robin within a class, plus refresh drain / PREA handling.
module cmd_arbiter
  import cmd_arbiter_pkg::*;
#(
  parameter int NUM_RNK               = 1,
  parameter int NUM_BG                = 4,
  parameter int NUM_BNK               = 4,
  parameter int RNK_SEL_WIDTH         = 1,
  parameter int BG_SEL_WIDTH          = 2,
  parameter int BNK_SEL_WIDTH         = 2,
  parameter int CMD_TYPE_WIDTH        = 3,
  parameter int NOP_BITS              = CMD_NOP,
  parameter int PRE_BITS              = CMD_PRE,
  parameter int ACT_BITS              = CMD_ACT,
  parameter int RD_BITS               = CMD_RD,
  parameter int WR_BITS               = CMD_WR,
  parameter int RDA_BITS              = CMD_RDA,
  parameter int WRA_BITS              = CMD_WRA,
  parameter int PREA_BITS             = CMD_PREA,
  parameter int TIME_CONSTRAINT_WIDTH = 8
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  cmd_arbiter_if.slave                                            req_if,
  input  logic [NUM_RNK*NUM_BG*NUM_BNK-1:0][3:0][TIME_CONSTRAINT_WIDTH-1:0] cmd_counter_i,
  input  logic [NUM_RNK-1:0][3:0]                                 faw_valid_i,
  input  logic                                                    ref_req_i,
  input  logic [RNK_SEL_WIDTH-1:0]                                ref_rnk_i,
  output logic                                                    ref_ack_o,
  output logic [CMD_TYPE_WIDTH-1:0]                               sel_cmd_o,
  output logic [RNK_SEL_WIDTH-1:0]                                sel_rnk_o,
  output logic [BG_SEL_WIDTH-1:0]                                 sel_bg_o,
  output logic [BNK_SEL_WIDTH-1:0]                                sel_bnk_o
);

  localparam int NUM_REQ       = NUM_RNK * NUM_BG * NUM_BNK;
  localparam int BANKS_PER_RNK = NUM_BG * NUM_BNK;
  localparam int PW            = RNK_SEL_WIDTH + BG_SEL_WIDTH + BNK_SEL_WIDTH;
  localparam int IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state, state_nx;
  logic [PW-1:0]      rr_ptr;
  logic               ref_ack;
  logic [NUM_REQ-1:0] elig, is_col, pre_busy;
  logic [NUM_REQ-1:0] col_req, row_req;
  logic               col_found, row_found, grant, pre_clear, prea_issue, normal;
  logic [PW-1:0]      col_idx, row_idx, gidx;
  logic [IW-1:0]      gsel;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    cmd_class_t cls;
    assign cls = classify(8'(req_if.req_cmd_i[g]), 8'(PRE_BITS), 8'(ACT_BITS),
                          8'(RD_BITS), 8'(WR_BITS), 8'(RDA_BITS), 8'(WRA_BITS));
    assign elig[g] = req_if.req_valid_i[g] && cls.ok
                     && (cmd_counter_i[g][cls.idx] == '0)
                     && !(cls.act && (faw_valid_i[g / BANKS_PER_RNK] == 4'hF));
    assign is_col[g]   = cls.col;
    assign pre_busy[g] = (cmd_counter_i[g][CIDX_PRE] != '0)
                         && ((g / BANKS_PER_RNK) == int'(ref_rnk_i));
  end

  assign normal  = (state == NORMAL) && !rst;
  assign col_req = elig & is_col & {NUM_REQ{normal}};
  assign row_req = elig & ~is_col & {NUM_REQ{normal}};

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_col_pick (
    .req(col_req), .ptr(rr_ptr), .found(col_found), .idx(col_idx)
  );

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_row_pick (
    .req(row_req), .ptr(rr_ptr), .found(row_found), .idx(row_idx)
  );

  assign grant      = col_found || row_found;
  assign gidx       = col_found ? col_idx : row_idx;
  assign gsel       = gidx[IW-1:0];
  assign pre_clear  = ~|pre_busy;
  assign prea_issue = !rst && (state == DRAIN) && ref_req_i && pre_clear;
  assign ref_ack_o  = ref_ack && !rst;

  // Grants only happen in NORMAL, so a grant and a PREA never collide
  always_comb begin
    req_if.req_ready_o = '0;
    sel_cmd_o          = CMD_TYPE_WIDTH'(NOP_BITS);
    sel_rnk_o          = '0;
    sel_bg_o           = '0;
    sel_bnk_o          = '0;
    if (grant) begin
      req_if.req_ready_o[gsel] = 1'b1;
      sel_cmd_o = req_if.req_cmd_i[gsel];
      sel_rnk_o = gidx[BNK_SEL_WIDTH+BG_SEL_WIDTH +: RNK_SEL_WIDTH];
      sel_bg_o  = gidx[BNK_SEL_WIDTH +: BG_SEL_WIDTH];
      sel_bnk_o = gidx[BNK_SEL_WIDTH-1:0];
    end else if (prea_issue) begin
      sel_cmd_o = CMD_TYPE_WIDTH'(PREA_BITS);
      sel_rnk_o = ref_rnk_i;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      NORMAL:  if (ref_req_i) state_nx = DRAIN;
      DRAIN: begin
        if (!ref_req_i)     state_nx = NORMAL;
        else if (pre_clear) state_nx = WAIT;
      end
      WAIT:    if (!ref_req_i) state_nx = NORMAL;
      default: state_nx = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= NORMAL;
      rr_ptr  <= '0;
      ref_ack <= 1'b0;
    end else begin
      state   <= state_nx;
      ref_ack <= (state_nx == WAIT);
      if (grant) begin
        rr_ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
      end
    end
  end

endmodule
